// File: rtl/tl_xbar_pkg.sv
// tl_xbar_pkg: shared constants, A-channel header struct and burst-length helper
// for the tl_xbar_nto1 crossbar.
package tl_xbar_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // A-channel header fields that travel with every beat alongside size/source/payload
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] param;
    logic       corrupt;
  } a_hdr_t;

  // Number of data beats an A message occupies; only Put messages larger than one beat burst
  function automatic logic [15:0] beats_from_size(input logic [2:0] opcode,
                                                  input int unsigned size,
                                                  input int unsigned beat_log2);
    logic [15:0] beats;
    if (((opcode == PUT_FULL) || (opcode == PUT_PARTIAL)) && (size > beat_log2)) begin
      beats = 16'd1 << (size - beat_log2);
    end else begin
      beats = 16'd1;
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_xbar_nto1_if.sv
// tl_xbar_nto1_if: bundles the N client A/D channels and the single manager A/D
// channel. Modport 'slave' is the crossbar's view, 'master' the environment's view.
interface tl_xbar_nto1_if #(
  parameter int N_IN   = 2,
  parameter int SRC_W  = 3,
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 3
);
  localparam int IDX_W      = $clog2(N_IN);
  localparam int OW         = SRC_W + IDX_W;
  localparam int BEAT_BYTES = DATA_W / 8;

  // client A
  logic [N_IN-1:0]            auto_in_a_valid;
  logic [N_IN-1:0]            auto_in_a_ready;
  logic [N_IN*3-1:0]          auto_in_a_bits_opcode;
  logic [N_IN*3-1:0]          auto_in_a_bits_param;
  logic [N_IN*SIZE_W-1:0]     auto_in_a_bits_size;
  logic [N_IN*SRC_W-1:0]      auto_in_a_bits_source;
  logic [N_IN*ADDR_W-1:0]     auto_in_a_bits_address;
  logic [N_IN*BEAT_BYTES-1:0] auto_in_a_bits_mask;
  logic [N_IN*DATA_W-1:0]     auto_in_a_bits_data;
  logic [N_IN-1:0]            auto_in_a_bits_corrupt;
  // client D
  logic [N_IN-1:0]            auto_in_d_ready;
  logic [N_IN-1:0]            auto_in_d_valid;
  logic [2:0]                 auto_in_d_bits_opcode;
  logic [SIZE_W-1:0]          auto_in_d_bits_size;
  logic [SRC_W-1:0]           auto_in_d_bits_source;
  logic [DATA_W-1:0]          auto_in_d_bits_data;
  // manager A
  logic                       auto_out_a_valid;
  logic                       auto_out_a_ready;
  logic [2:0]                 auto_out_a_bits_opcode;
  logic [2:0]                 auto_out_a_bits_param;
  logic [SIZE_W-1:0]          auto_out_a_bits_size;
  logic [OW-1:0]              auto_out_a_bits_source;
  logic [ADDR_W-1:0]          auto_out_a_bits_address;
  logic [BEAT_BYTES-1:0]      auto_out_a_bits_mask;
  logic [DATA_W-1:0]          auto_out_a_bits_data;
  logic                       auto_out_a_bits_corrupt;
  // manager D
  logic                       auto_out_d_valid;
  logic                       auto_out_d_ready;
  logic [2:0]                 auto_out_d_bits_opcode;
  logic [SIZE_W-1:0]          auto_out_d_bits_size;
  logic [OW-1:0]              auto_out_d_bits_source;
  logic [DATA_W-1:0]          auto_out_d_bits_data;

  modport slave (
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt, auto_in_d_ready,
           auto_out_a_ready, auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_data,
    output auto_in_a_ready, auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_data,
           auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt, auto_out_d_ready
  );

  modport master (
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt, auto_in_d_ready,
           auto_out_a_ready, auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_data,
    input  auto_in_a_ready, auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_data,
           auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt, auto_out_d_ready
  );

endinterface

// File: rtl/tl_rr_arbiter.sv
// tl_rr_arbiter: N-way round-robin arbiter. While i_lock is high the grant is
// forced to i_lock_idx and the pointer holds; otherwise a fire moves the
// pointer one past the winner.
module tl_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     i_req,
  input  logic             i_lock,
  input  logic [IDX_W-1:0] i_lock_idx,
  input  logic             i_fire,
  output logic [IDX_W-1:0] o_grant
);

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_scan;
  logic             w_found;

  // Scan from the pointer upward first, then wrap to the low indices
  always_comb begin
    w_scan  = r_rr_ptr;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && (i >= int'(r_rr_ptr)) && i_req[i]) begin
        w_scan  = IDX_W'(i);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i]) begin
        w_scan  = IDX_W'(i);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_grant = i_lock ? i_lock_idx : w_scan;

  // Advance the pointer past the winner on an unlocked (first-beat) fire
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= IDX_W'(0);
    end else if (i_fire && !i_lock) begin
      r_rr_ptr <= (o_grant == IDX_W'(N - 1)) ? IDX_W'(0) : (o_grant + IDX_W'(1));
    end
  end

endmodule

// File: rtl/tl_xbar_nto1.sv
// tl_xbar_nto1: TileLink-UL N:1 crossbar. Round-robin A arbitration with burst
// locking, source-ID extension on A, source-based D routing, sticky misroute flag.
// Optional macro TL_XBAR_A_SLICE_EN inserts a 2-entry skid register on manager A.
module tl_xbar_nto1
  import tl_xbar_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SRC_W  = 3,
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 3
) (
  input  logic          clock,
  input  logic          reset,
  tl_xbar_nto1_if.slave bus,
  output logic          d_route_err
);

  localparam int IDX_W      = $clog2(N_IN);
  localparam int OW         = SRC_W + IDX_W;
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BEAT_LOG2  = $clog2(BEAT_BYTES);
  localparam int BEAT_W     = $bits(a_hdr_t) + SIZE_W + OW + ADDR_W + BEAT_BYTES + DATA_W;

  logic [IDX_W-1:0]      w_grant;
  logic [N_IN-1:0]       w_grant_oh;
  logic                  w_mux_valid;
  logic                  w_mux_ready;
  logic                  w_mux_fire;
  a_hdr_t                w_hdr;
  logic [SIZE_W-1:0]     w_size;
  logic [SRC_W-1:0]      w_src_lo;
  logic [ADDR_W-1:0]     w_addr;
  logic [BEAT_BYTES-1:0] w_mask;
  logic [DATA_W-1:0]     w_data;
  logic [15:0]           w_beats;
  logic [BEAT_W-1:0]     w_mux_beat;
  logic [BEAT_W-1:0]     w_out_beat;
  a_hdr_t                w_out_hdr;

  logic                  r_locked;
  logic [15:0]           r_beats_left;
  logic [IDX_W-1:0]      r_lock_idx;

  tl_rr_arbiter #(.N(N_IN), .IDX_W(IDX_W)) u_arb (
    .clock      (clock),
    .reset      (reset),
    .i_req      (bus.auto_in_a_valid),
    .i_lock     (r_locked),
    .i_lock_idx (r_lock_idx),
    .i_fire     (w_mux_fire),
    .o_grant    (w_grant)
  );

  // AND-OR mux of the granted client's A beat
  always_comb begin
    w_hdr    = '0;
    w_size   = '0;
    w_src_lo = '0;
    w_addr   = '0;
    w_mask   = '0;
    w_data   = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_grant_oh[i]  = (w_grant == IDX_W'(i));
      w_hdr.opcode   = w_hdr.opcode  | (bus.auto_in_a_bits_opcode[3*i +: 3] & {3{w_grant_oh[i]}});
      w_hdr.param    = w_hdr.param   | (bus.auto_in_a_bits_param[3*i +: 3]  & {3{w_grant_oh[i]}});
      w_hdr.corrupt  = w_hdr.corrupt | (bus.auto_in_a_bits_corrupt[i] & w_grant_oh[i]);
      w_size   = w_size   | (bus.auto_in_a_bits_size[SIZE_W*i +: SIZE_W]       & {SIZE_W{w_grant_oh[i]}});
      w_src_lo = w_src_lo | (bus.auto_in_a_bits_source[SRC_W*i +: SRC_W]      & {SRC_W{w_grant_oh[i]}});
      w_addr   = w_addr   | (bus.auto_in_a_bits_address[ADDR_W*i +: ADDR_W]   & {ADDR_W{w_grant_oh[i]}});
      w_mask   = w_mask   | (bus.auto_in_a_bits_mask[BEAT_BYTES*i +: BEAT_BYTES] & {BEAT_BYTES{w_grant_oh[i]}});
      w_data   = w_data   | (bus.auto_in_a_bits_data[DATA_W*i +: DATA_W]      & {DATA_W{w_grant_oh[i]}});
    end
  end

  assign w_mux_valid          = |(bus.auto_in_a_valid & w_grant_oh);
  assign w_mux_fire           = w_mux_valid & w_mux_ready;
  assign bus.auto_in_a_ready  = w_grant_oh & {N_IN{w_mux_ready}};
  assign w_beats              = beats_from_size(w_hdr.opcode, 32'(w_size), BEAT_LOG2);
  assign w_mux_beat           = {w_hdr, w_size, w_grant, w_src_lo, w_addr, w_mask, w_data};

  // Burst lock: freeze the grant for the remaining beats of a multi-beat Put
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_locked     <= 1'b0;
      r_beats_left <= 16'd0;
      r_lock_idx   <= IDX_W'(0);
    end else if (w_mux_fire) begin
      if (!r_locked) begin
        if (w_beats > 16'd1) begin
          r_locked     <= 1'b1;
          r_beats_left <= w_beats - 16'd1;
          r_lock_idx   <= w_grant;
        end
      end else begin
        r_beats_left <= r_beats_left - 16'd1;
        if (r_beats_left == 16'd1) begin
          r_locked <= 1'b0;
        end
      end
    end
  end

`ifdef TL_XBAR_A_SLICE_EN
  logic [BEAT_W-1:0] r_slot [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;
  logic              w_out_fire;

  assign w_mux_ready          = (r_cnt != 2'd2);
  assign bus.auto_out_a_valid = (r_cnt != 2'd0);
  assign w_out_beat           = r_slot[r_rptr];
  assign w_out_fire           = bus.auto_out_a_valid & bus.auto_out_a_ready;

  // Two-entry skid buffer between the A mux and the manager port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_mux_fire) begin
        r_slot[r_wptr] <= w_mux_beat;
        r_wptr         <= ~r_wptr;
      end
      if (w_out_fire) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_mux_fire, w_out_fire})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  assign w_mux_ready          = bus.auto_out_a_ready;
  assign bus.auto_out_a_valid = w_mux_valid;
  assign w_out_beat           = w_mux_beat;
`endif

  assign {w_out_hdr, bus.auto_out_a_bits_size, bus.auto_out_a_bits_source,
          bus.auto_out_a_bits_address, bus.auto_out_a_bits_mask,
          bus.auto_out_a_bits_data} = w_out_beat;
  assign bus.auto_out_a_bits_opcode  = w_out_hdr.opcode;
  assign bus.auto_out_a_bits_param   = w_out_hdr.param;
  assign bus.auto_out_a_bits_corrupt = w_out_hdr.corrupt;

  // D routing: the extended source MSBs select the client; out-of-range indices are dropped
  logic [IDX_W-1:0] w_d_idx;
  logic             w_d_ok;
  logic [N_IN-1:0]  w_d_oh;
  logic             r_d_route_err;

  assign w_d_idx = bus.auto_out_d_bits_source[OW-1 -: IDX_W];
  assign w_d_ok  = ({1'b0, w_d_idx} < (IDX_W+1)'(N_IN));

  // One-hot D destination
  always_comb begin
    w_d_oh = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_d_oh[i] = (w_d_idx == IDX_W'(i));
    end
  end

  assign bus.auto_in_d_valid       = w_d_oh & {N_IN{bus.auto_out_d_valid & w_d_ok}};
  assign bus.auto_out_d_ready      = w_d_ok ? (|(bus.auto_in_d_ready & w_d_oh)) : 1'b1;
  assign bus.auto_in_d_bits_opcode = bus.auto_out_d_bits_opcode;
  assign bus.auto_in_d_bits_size   = bus.auto_out_d_bits_size;
  assign bus.auto_in_d_bits_source = bus.auto_out_d_bits_source[SRC_W-1:0];
  assign bus.auto_in_d_bits_data   = bus.auto_out_d_bits_data;

  // Sticky flag set whenever a misrouted D beat is consumed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_route_err <= 1'b0;
    end else if (bus.auto_out_d_valid && !w_d_ok) begin
      r_d_route_err <= 1'b1;
    end
  end

  assign d_route_err = r_d_route_err;

endmodule

// File: tb/tb_tl_xbar_nto1.sv
// tb_tl_xbar_nto1: scoreboard bench. A 2-client crossbar exercises A arbitration,
// burst locking and D routing; a 3-client crossbar exercises the misroute flag.
module tb_tl_xbar_nto1;
  import tl_xbar_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_xbar_nto1_if #(.N_IN(2), .SRC_W(3), .ADDR_W(31), .DATA_W(64), .SIZE_W(3)) b2 ();
  tl_xbar_nto1_if #(.N_IN(3), .SRC_W(3), .ADDR_W(31), .DATA_W(64), .SIZE_W(3)) b3 ();
  logic err2, err3;

  tl_xbar_nto1 #(.N_IN(2), .SRC_W(3), .ADDR_W(31), .DATA_W(64), .SIZE_W(3)) u_dut2 (
    .clock(clk), .reset(rst_n), .bus(b2), .d_route_err(err2));
  tl_xbar_nto1 #(.N_IN(3), .SRC_W(3), .ADDR_W(31), .DATA_W(64), .SIZE_W(3)) u_dut3 (
    .clock(clk), .reset(rst_n), .bus(b3), .d_route_err(err3));

  localparam logic [2:0] GET = 3'd4;

  typedef struct { logic [2:0] op; logic [2:0] size; logic [2:0] src; int tag; int beats; } req_t;
  typedef struct { logic [3:0] src; logic [63:0] data; } exp_t;

  req_t cq [2][$];
  exp_t exp_q [$];
  int   beat_no [2];
  logic [1:0] fired;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic req(input int c, input logic [2:0] op, input logic [2:0] size,
                     input logic [2:0] src, input int tag, input int beats);
    req_t r;
    r.op = op; r.size = size; r.src = src; r.tag = tag; r.beats = beats;
    cq[c].push_back(r);
  endtask

  task automatic expect_msg(input int c, input logic [2:0] src, input int tag, input int beats);
    exp_t e;
    for (int b = 0; b < beats; b++) begin
      e.src  = {c[0], src};
      e.data = {32'(tag), 32'(b)};
      exp_q.push_back(e);
    end
  endtask

  // Present each client's head-of-queue beat
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (cq[i].size() != 0) begin
        b2.auto_in_a_valid[i]              = 1'b1;
        b2.auto_in_a_bits_opcode[3*i +: 3] = cq[i][0].op;
        b2.auto_in_a_bits_size[3*i +: 3]   = cq[i][0].size;
        b2.auto_in_a_bits_source[3*i +: 3] = cq[i][0].src;
        b2.auto_in_a_bits_address[31*i +: 31] = 31'(32'h1000 * (i + 1));
        b2.auto_in_a_bits_data[64*i +: 64] = {32'(cq[i][0].tag), 32'(beat_no[i])};
      end else begin
        b2.auto_in_a_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit toggle);
    @(negedge clk);
    fired = b2.auto_in_a_valid & b2.auto_in_a_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (fired[i]) begin
        beat_no[i]++;
        if (beat_no[i] == cq[i][0].beats) begin
          void'(cq[i].pop_front());
          beat_no[i] = 0;
        end
      end
    end
    if (toggle) b2.auto_out_a_ready = ~b2.auto_out_a_ready;
    drive();
  endtask

  task automatic run(input bit toggle, input string name);
    int budget = 200;
    while (((cq[0].size() != 0) || (cq[1].size() != 0)) && (budget > 0)) begin
      step(toggle);
      budget--;
    end
    chk({name, "_budget_expired"}, 64'(budget == 0), 64'd0);
    repeat (3) step(1'b0);
    chk({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every manager A fire must match the next expected beat
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b2.auto_out_a_valid && b2.auto_out_a_ready) begin
      if (exp_q.size() == 0) begin
        chk("a_unexpected_beat", {60'd0, b2.auto_out_a_bits_source}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("a_source", 64'(b2.auto_out_a_bits_source), 64'(e.src));
        chk("a_data", b2.auto_out_a_bits_data, e.data);
`ifndef TL_XBAR_A_SLICE_EN
        chk("a_other_ready", 64'(b2.auto_in_a_ready[~b2.auto_out_a_bits_source[3]]), 64'd0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b2.auto_in_a_valid = '0; b2.auto_in_a_bits_opcode = '0; b2.auto_in_a_bits_param = '0;
    b2.auto_in_a_bits_size = '0; b2.auto_in_a_bits_source = '0; b2.auto_in_a_bits_address = '0;
    b2.auto_in_a_bits_mask = '1; b2.auto_in_a_bits_data = '0; b2.auto_in_a_bits_corrupt = '0;
    b2.auto_in_d_ready = '0; b2.auto_out_a_ready = 1'b0; b2.auto_out_d_valid = 1'b0;
    b2.auto_out_d_bits_opcode = '0; b2.auto_out_d_bits_size = '0;
    b2.auto_out_d_bits_source = '0; b2.auto_out_d_bits_data = '0;
    b3.auto_in_a_valid = '0; b3.auto_in_a_bits_opcode = '0; b3.auto_in_a_bits_param = '0;
    b3.auto_in_a_bits_size = '0; b3.auto_in_a_bits_source = '0; b3.auto_in_a_bits_address = '0;
    b3.auto_in_a_bits_mask = '0; b3.auto_in_a_bits_data = '0; b3.auto_in_a_bits_corrupt = '0;
    b3.auto_in_d_ready = '0; b3.auto_out_a_ready = 1'b0; b3.auto_out_d_valid = 1'b0;
    b3.auto_out_d_bits_opcode = '0; b3.auto_out_d_bits_size = '0;
    b3.auto_out_d_bits_source = '0; b3.auto_out_d_bits_data = '0;
    beat_no[0] = 0; beat_no[1] = 0;

    // Reset held while both clients request; then alternating Gets
    req(0, GET, 3'd3, 3'd1, 1, 1);  req(0, GET, 3'd3, 3'd2, 2, 1);  req(0, GET, 3'd3, 3'd3, 3, 1);
    req(1, GET, 3'd3, 3'd4, 11, 1); req(1, GET, 3'd3, 3'd5, 12, 1); req(1, GET, 3'd3, 3'd6, 13, 1);
    expect_msg(0, 3'd1, 1, 1);  expect_msg(1, 3'd4, 11, 1);
    expect_msg(0, 3'd2, 2, 1);  expect_msg(1, 3'd5, 12, 1);
    expect_msg(0, 3'd3, 3, 1);  expect_msg(1, 3'd6, 13, 1);
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifndef TL_XBAR_A_SLICE_EN
    chk("rst_out_valid", 64'(b2.auto_out_a_valid), 64'd1);
    chk("rst_out_source", 64'(b2.auto_out_a_bits_source), 64'h1);
`endif
    chk("rst_err2", 64'(err2), 64'd0);
    chk("rst_err3", 64'(err3), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b2.auto_out_a_ready = 1'b1;
    run(1'b0, "alt");

    // 4-beat PutFull from client 0 against a single-beat Get (size 5) from client 1
    req(0, PUT_FULL, 3'd5, 3'd7, 21, 4);
    req(1, GET, 3'd5, 3'd2, 22, 1);
    expect_msg(0, 3'd7, 21, 4);
    expect_msg(1, 3'd2, 22, 1);
    drive();
    run(1'b0, "burst");

    // Bursts under a toggling manager ready
    req(0, PUT_FULL, 3'd5, 3'd3, 31, 4);
    req(0, GET, 3'd3, 3'd4, 32, 1);
    req(1, PUT_PARTIAL, 3'd4, 3'd1, 41, 2);
    expect_msg(0, 3'd3, 31, 4);
    expect_msg(1, 3'd1, 41, 2);
    expect_msg(0, 3'd4, 32, 1);
    drive();
    run(1'b1, "stall");

    // D routing on the 2-client crossbar
    @(posedge clk); #1;
    b2.auto_out_d_valid = 1'b1;
    b2.auto_out_d_bits_opcode = ACCESS_ACK_DATA;
    b2.auto_out_d_bits_size = 3'd3;
    b2.auto_out_d_bits_source = {1'b1, 3'd5};
    b2.auto_out_d_bits_data = 64'hDEAD_BEEF_0123_4567;
    b2.auto_in_d_ready = 2'b01;
    @(negedge clk);
    chk("d_valid_c1", 64'(b2.auto_in_d_valid), 64'h2);
    chk("d_source_c1", 64'(b2.auto_in_d_bits_source), 64'd5);
    chk("d_data", b2.auto_in_d_bits_data, 64'hDEAD_BEEF_0123_4567);
    chk("d_ready_stall", 64'(b2.auto_out_d_ready), 64'd0);
    b2.auto_in_d_ready = 2'b10;
    #1;
    chk("d_ready_go", 64'(b2.auto_out_d_ready), 64'd1);
    @(posedge clk); #1;
    b2.auto_out_d_bits_source = {1'b0, 3'd2};
    b2.auto_in_d_ready = 2'b01;
    @(negedge clk);
    chk("d_valid_c0", 64'(b2.auto_in_d_valid), 64'h1);
    chk("d_source_c0", 64'(b2.auto_in_d_bits_source), 64'd2);
    chk("d_ready_c0", 64'(b2.auto_out_d_ready), 64'd1);
    @(posedge clk); #1;
    b2.auto_out_d_valid = 1'b0;
    @(negedge clk);
    chk("d_valid_idle", 64'(b2.auto_in_d_valid), 64'h0);

    // Misroute on the 3-client crossbar
    chk("err3_before", 64'(err3), 64'd0);
    @(posedge clk); #1;
    b3.auto_out_d_valid = 1'b1;
    b3.auto_out_d_bits_source = {2'd3, 3'd1};
    b3.auto_in_d_ready = 3'b000;
    @(negedge clk);
    chk("mis_ready", 64'(b3.auto_out_d_ready), 64'd1);
    chk("mis_valid", 64'(b3.auto_in_d_valid), 64'h0);
    @(posedge clk); #1;
    b3.auto_out_d_bits_source = {2'd2, 3'd4};
    b3.auto_in_d_ready = 3'b100;
    @(negedge clk);
    chk("mis_err_set", 64'(err3), 64'd1);
    chk("ok_valid_c2", 64'(b3.auto_in_d_valid), 64'h4);
    chk("ok_source_c2", 64'(b3.auto_in_d_bits_source), 64'd4);
    @(posedge clk); #1;
    b3.auto_out_d_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mis_err_sticky", 64'(err3), 64'd1);
    chk("err2_clean", 64'(err2), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mis_err_async_clr", 64'(err3), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mis_err_after_rst", 64'(err3), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
